// File: rtl/power_pa_sequencer_if.sv
// Bus between the baseband transmit controller and the PA/LNA/T-R switch
// sequencer. The controller side drives requests and bias; the sequencer
// side drives the analog enables, the bias code and status.
interface power_pa_sequencer_if #(
  parameter int BIAS_WIDTH = 8
);
  logic                  tx_request;
  logic [BIAS_WIDTH-1:0] bias_target;
  logic                  temp_alarm;
  logic                  fault_clear;
  logic                  enable_receive;
  logic                  switch_tx;
  logic                  enable_transmit;
  logic [BIAS_WIDTH-1:0] pa_bias;
  logic                  tx_grant;
  logic                  busy;
  logic                  fault;

  modport master (
    output tx_request, bias_target, temp_alarm, fault_clear,
    input  enable_receive, switch_tx, enable_transmit, pa_bias,
    input  tx_grant, busy, fault
  );

  modport slave (
    input  tx_request, bias_target, temp_alarm, fault_clear,
    output enable_receive, switch_tx, enable_transmit, pa_bias,
    output tx_grant, busy, fault
  );
endinterface

// File: rtl/power_pa_sequencer.sv
// Receive/transmit changeover sequencer for a shared antenna.
// Up path: LNA off, guard, switch to PA, settle, ramp PA bias, grant.
// Down path: ramp bias to zero, switch to LNA, settle, guard, LNA on.
// Every output is registered from the next-state/next-bias values so the
// analog enables change cleanly on the clock edge.
module power_pa_sequencer #(
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int BIAS_WIDTH    = 8,
  parameter int BIAS_STEP     = 16,
  parameter int MAX_TX_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  power_pa_sequencer_if.slave  bus
);

  localparam int HOLD_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX  = (HOLD_MAX > MAX_TX_CYCLES) ? HOLD_MAX : MAX_TX_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BW1      = BIAS_WIDTH + 1;

  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(MAX_TX_CYCLES - 1);
  localparam logic [BW1-1:0]   STEP_EXT    = BW1'(BIAS_STEP);

  typedef enum logic [2:0] {
    IDLE,
    RX_OFF,
    SWITCH_TX,
    RAMP_UP,
    ACTIVE,
    RAMP_DOWN,
    SWITCH_RX,
    RX_ON
  } state_t;

  state_t                state_q;
  state_t                state_n;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_n;
  logic [BIAS_WIDTH-1:0] bias_q;
  logic [BIAS_WIDTH-1:0] bias_n;
  logic [BIAS_WIDTH-1:0] target_q;
  logic                  load_target;
  logic                  fault_q;
  logic                  fault_n;
  logic                  timeout;
  logic                  abort;

  logic                  enable_receive_q;
  logic                  switch_tx_q;
  logic                  enable_transmit_q;
  logic                  tx_grant_q;
  logic                  busy_q;

  // Saturating ramp-up step: the sum is formed one bit wider so a step
  // past the top of the DAC range clamps to the target instead of wrapping.
  function automatic logic [BIAS_WIDTH-1:0] ramp_up_step(
    input logic [BIAS_WIDTH-1:0] cur,
    input logic [BIAS_WIDTH-1:0] tgt
  );
    logic [BW1-1:0] sum;
    sum = {1'b0, cur} + STEP_EXT;
    if (sum >= {1'b0, tgt}) begin
      ramp_up_step = tgt;
    end else begin
      ramp_up_step = sum[BIAS_WIDTH-1:0];
    end
  endfunction

  // Floor-at-zero ramp-down step: never underflows below code 0.
  function automatic logic [BIAS_WIDTH-1:0] ramp_down_step(
    input logic [BIAS_WIDTH-1:0] cur
  );
    if ({1'b0, cur} <= STEP_EXT) begin
      ramp_down_step = '0;
    end else begin
      ramp_down_step = cur - STEP_EXT[BIAS_WIDTH-1:0];
    end
  endfunction

  // Next-state, hold counter and bias ramp. A release or over-temperature
  // abort takes priority over a hold that completes on the same cycle.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q + 1'b1;
    bias_n      = bias_q;
    load_target = 1'b0;
    timeout     = 1'b0;
    abort       = !bus.tx_request || bus.temp_alarm;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (bus.tx_request && !fault_q) begin
          state_n     = RX_OFF;
          load_target = 1'b1;
        end
      end
      RX_OFF: begin
        if (abort) begin
          state_n = RX_ON;
        end else if (cnt_q == GUARD_LAST) begin
          state_n = SWITCH_TX;
        end
      end
      SWITCH_TX: begin
        if (abort) begin
          state_n = SWITCH_RX;
        end else if (cnt_q == SETTLE_LAST) begin
          state_n = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (abort) begin
          state_n = RAMP_DOWN;
        end else begin
          bias_n = ramp_up_step(bias_q, target_q);
          if (bias_n == target_q) begin
            state_n = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        timeout = (cnt_q == TX_LAST);
        if (abort || timeout) begin
          state_n = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        bias_n = ramp_down_step(bias_q);
        if (bias_n == '0) begin
          state_n = SWITCH_RX;
        end
      end
      SWITCH_RX: begin
        if (cnt_q == SETTLE_LAST) begin
          state_n = RX_ON;
        end
      end
      RX_ON: begin
        if (cnt_q == GUARD_LAST) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state_n != state_q) begin
      cnt_n = '0;
    end
  end

  // Sticky fault: an alarm or timeout on the same cycle as a clear wins.
  always_comb begin
    fault_n = fault_q;
    if (bus.fault_clear) begin
      fault_n = 1'b0;
    end
    if ((bus.temp_alarm && (state_q != IDLE)) || timeout) begin
      fault_n = 1'b1;
    end
  end

  // Control state, counter, bias and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bias_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bias_q  <= bias_n;
      fault_q <= fault_n;
    end
  end

  // Burst target, captured as the sequencer leaves IDLE.
  always_ff @(posedge clk) begin
    if (load_target) begin
      target_q <= bus.bias_target;
    end
  end

  // Registered analog enables and status, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_receive_q  <= 1'b1;
      switch_tx_q       <= 1'b0;
      enable_transmit_q <= 1'b0;
      tx_grant_q        <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      enable_receive_q  <= (state_n == IDLE);
      switch_tx_q       <= (state_n == SWITCH_TX) || (state_n == RAMP_UP) ||
                           (state_n == ACTIVE)    || (state_n == RAMP_DOWN);
      enable_transmit_q <= (state_n == RAMP_UP) || (state_n == ACTIVE) ||
                           (state_n == RAMP_DOWN);
      tx_grant_q        <= (state_n == ACTIVE);
      busy_q            <= (state_n != IDLE);
    end
  end

  assign bus.enable_receive  = enable_receive_q;
  assign bus.switch_tx       = switch_tx_q;
  assign bus.enable_transmit = enable_transmit_q;
  assign bus.pa_bias         = bias_q;
  assign bus.tx_grant        = tx_grant_q;
  assign bus.busy            = busy_q;
  assign bus.fault           = fault_q;

endmodule

// File: tb/tb_power_pa_sequencer.sv
// Bench for power_pa_sequencer: directed timing scenarios followed by a
// randomized request/alarm/clear stream, all checked cycle by cycle against
// a phase/countdown reference model of the changeover sequence.
module tb_power_pa_sequencer;

  localparam int G     = 4;
  localparam int S     = 8;
  localparam int W     = 8;
  localparam int STEP  = 16;
  localparam int MAXTX = 16;

  localparam int PH_IDLE   = 0;
  localparam int PH_RXOFF  = 1;
  localparam int PH_SWTX   = 2;
  localparam int PH_RAMPUP = 3;
  localparam int PH_ACTIVE = 4;
  localparam int PH_RAMPDN = 5;
  localparam int PH_SWRX   = 6;
  localparam int PH_RXON   = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase, m_left, m_bias, m_target;
  bit m_fault;

  int e_a, e_b, e_c, e_d, prev, req_left, pick;
  bit et_seen;
  logic [7:0] up_q[$];
  logic [7:0] dn_q[$];

  power_pa_sequencer_if #(.BIAS_WIDTH(W)) bus ();

  power_pa_sequencer #(
    .GUARD_CYCLES (G),
    .SETTLE_CYCLES(S),
    .BIAS_WIDTH   (W),
    .BIAS_STEP    (STEP),
    .MAX_TX_CYCLES(MAXTX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_left   = 0;
    m_bias   = 0;
    m_target = 0;
    m_fault  = 1'b0;
  endtask

  task automatic go(input int ph, input int len);
    m_phase = ph;
    m_left  = len;
  endtask

  // One clock of the changeover sequence, from the inputs seen at the edge.
  task automatic model_step();
    bit req, alarm, clr, abort, hit;
    int nb;
    req   = bus.tx_request;
    alarm = bus.temp_alarm;
    clr   = bus.fault_clear;
    abort = !req || alarm;
    hit   = alarm && (m_phase != PH_IDLE);
    case (m_phase)
      PH_IDLE: if (req && !m_fault) begin
        m_target = int'(bus.bias_target);
        go(PH_RXOFF, G);
      end
      PH_RXOFF: if (abort) go(PH_RXON, G);
                else begin m_left--; if (m_left == 0) go(PH_SWTX, S); end
      PH_SWTX:  if (abort) go(PH_SWRX, S);
                else begin m_left--; if (m_left == 0) go(PH_RAMPUP, 0); end
      PH_RAMPUP: if (abort) go(PH_RAMPDN, 0);
                 else begin
                   nb = m_bias + STEP;
                   m_bias = (nb > m_target) ? m_target : nb;
                   if (m_bias == m_target) go(PH_ACTIVE, MAXTX);
                 end
      PH_ACTIVE: begin
        m_left--;
        if (m_left == 0) hit = 1'b1;
        if (abort || m_left == 0) go(PH_RAMPDN, 0);
      end
      PH_RAMPDN: begin
        m_bias = (m_bias > STEP) ? m_bias - STEP : 0;
        if (m_bias == 0) go(PH_SWRX, S);
      end
      PH_SWRX: begin m_left--; if (m_left == 0) go(PH_RXON, G); end
      PH_RXON: begin m_left--; if (m_left == 0) go(PH_IDLE, 0); end
      default: go(PH_IDLE, 0);
    endcase
    if (hit) m_fault = 1'b1;
    else if (clr) m_fault = 1'b0;
  endtask

  function automatic int dut_flags();
    return int'({bus.enable_receive, bus.switch_tx, bus.enable_transmit,
                 bus.tx_grant, bus.busy, bus.fault});
  endfunction

  function automatic int exp_flags();
    bit er, sw, et, gr;
    er = (m_phase == PH_IDLE);
    sw = (m_phase >= PH_SWTX) && (m_phase <= PH_RAMPDN);
    et = (m_phase >= PH_RAMPUP) && (m_phase <= PH_RAMPDN);
    gr = (m_phase == PH_ACTIVE);
    return int'({er, sw, et, gr, !er, m_fault});
  endfunction

  // Advance one edge, step the model and compare outputs and invariants.
  task automatic tick();
    int viol;
    @(posedge clk);
    #1;
    model_step();
    chk("flags", dut_flags(), exp_flags());
    chk("bias", int'(bus.pa_bias), m_bias);
    viol = 0;
    if (bus.enable_receive && bus.switch_tx) viol |= 1;
    if (bus.enable_transmit && !bus.switch_tx) viol |= 2;
    if ((bus.pa_bias != 0) && !bus.enable_transmit) viol |= 4;
    if (bus.tx_grant && (int'(bus.pa_bias) != m_target)) viol |= 8;
    chk("invariant", viol, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy && k < 300) begin tick(); k++; end
    chk(tag, int'(bus.busy), 0);
  endtask

  task automatic wait_grant(input string tag);
    int k;
    k = 0;
    while (!bus.tx_grant && k < 300) begin tick(); k++; end
    chk(tag, int'(bus.tx_grant), 1);
  endtask

  task automatic pulse_clear();
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    chk("fault_cleared", int'(bus.fault), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.tx_request  = 1'b0;
    bus.bias_target = '0;
    bus.temp_alarm  = 1'b0;
    bus.fault_clear = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("reset_flags", dut_flags(), 6'b100000);
    chk("reset_bias", int'(bus.pa_bias), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Request to grant with target 0x80
    bus.tx_request  = 1'b1;
    bus.bias_target = 8'h80;
    e_a = -1; e_b = -1; e_c = -1;
    for (int k = 1; k <= 200 && e_c < 0; k++) begin
      tick();
      if (e_a < 0 && !bus.enable_receive) e_a = k;
      if (e_b < 0 && bus.switch_tx) e_b = k;
      if (e_c < 0 && bus.tx_grant) e_c = k;
    end
    chk("rx_fall_edge", e_a, 1);
    chk("sw_rise_edge", e_b, 1 + G);
    chk("grant_edge", e_c, G + S + ceil_div(128, STEP) + 1);

    // Release back to receive
    bus.tx_request = 1'b0;
    e_a = -1; e_b = -1; e_c = -1; e_d = -1;
    for (int k = 1; k <= 200 && e_d < 0; k++) begin
      tick();
      if (e_a < 0 && !bus.tx_grant) e_a = k;
      if (e_b < 0 && bus.pa_bias == 0) e_b = k;
      if (e_c < 0 && !bus.switch_tx) e_c = k;
      if (e_d < 0 && bus.enable_receive) e_d = k;
    end
    chk("grant_fall_edge", e_a, 1);
    chk("bias_zero_edge", e_b, 1 + ceil_div(128, STEP));
    chk("sw_fall_edge", e_c, 1 + ceil_div(128, STEP));
    chk("rx_back_edge", e_d, ceil_div(128, STEP) + S + G + 1);
    chk("busy_after_release", int'(bus.busy), 0);

    // Ramp near the top of the DAC range: 0xF5
    bus.tx_request  = 1'b1;
    bus.bias_target = 8'hF5;
    prev = 0;
    for (int k = 0; k < 300 && !bus.tx_grant; k++) begin
      tick();
      if (int'(bus.pa_bias) != prev) begin up_q.push_back(bus.pa_bias); prev = int'(bus.pa_bias); end
    end
    bus.tx_request = 1'b0;
    for (int k = 0; k < 300 && (k == 0 || bus.enable_transmit); k++) begin
      tick();
      if (int'(bus.pa_bias) != prev) begin dn_q.push_back(bus.pa_bias); prev = int'(bus.pa_bias); end
    end
    chk("up_steps", up_q.size(), 16);
    chk("up_second_last", int'(up_q[14]), 8'hF0);
    chk("up_last", int'(up_q[15]), 8'hF5);
    chk("dn_steps", dn_q.size(), 16);
    chk("dn_first", int'(dn_q[0]), 8'hE5);
    chk("dn_second_last", int'(dn_q[14]), 8'h05);
    chk("dn_last", int'(dn_q[15]), 0);
    wait_idle("f5_idle");

    // Over-temperature in ACTIVE, then request blocked until cleared
    bus.tx_request  = 1'b1;
    bus.bias_target = 8'($urandom_range(1, 255));
    wait_grant("alarm_grant_reached");
    bus.temp_alarm = 1'b1;
    tick();
    bus.temp_alarm = 1'b0;
    chk("alarm_fault", int'(bus.fault), 1);
    chk("alarm_grant_drop", int'(bus.tx_grant), 0);
    wait_idle("alarm_idle");
    for (int k = 0; k < 5; k++) tick();
    chk("fault_blocks_req", int'(bus.busy), 0);
    pulse_clear();
    chk("still_idle_on_clear", int'(bus.busy), 0);
    tick();
    chk("req_accepted", int'(bus.busy), 1);
    bus.tx_request = 1'b0;
    wait_idle("accept_idle");

    // Release during SWITCH_TX; alarm and clear together on the down path
    tick();
    bus.tx_request  = 1'b1;
    bus.bias_target = 8'h80;
    et_seen = 1'b0;
    e_a = -1; e_b = -1;
    for (int k = 1; k <= 200 && e_b < 0; k++) begin
      bus.temp_alarm  = (k == 9);
      bus.fault_clear = (k == 9);
      tick();
      if (k == 9) chk("alarm_beats_clear", int'(bus.fault), 1);
      if (k == 5) bus.tx_request = 1'b0;
      if (bus.enable_transmit) et_seen = 1'b1;
      if (k >= 6 && e_a < 0 && !bus.switch_tx) e_a = k;
      if (k > 1 && e_b < 0 && !bus.busy) e_b = k;
    end
    bus.temp_alarm  = 1'b0;
    bus.fault_clear = 1'b0;
    chk("no_pa_enable", int'(et_seen), 0);
    chk("swtx_abort_sw_fall", e_a, 6);
    chk("swtx_abort_idle", e_b, 6 + S + G);
    pulse_clear();

    // ACTIVE timeout
    bus.tx_request  = 1'b1;
    bus.bias_target = 8'($urandom_range(0, 255));
    wait_grant("timeout_grant_reached");
    e_a = -1;
    for (int k = 1; k <= 100 && e_a < 0; k++) begin
      tick();
      if (bus.fault) e_a = k;
    end
    chk("timeout_cycles", e_a, MAXTX);
    chk("timeout_grant_drop", int'(bus.tx_grant), 0);
    bus.tx_request = 1'b0;
    wait_idle("timeout_idle");
    pulse_clear();

    // Asynchronous reset in the middle of RAMP_UP
    bus.tx_request  = 1'b1;
    bus.bias_target = 8'hC0;
    for (int k = 0; k < 100 && bus.pa_bias == 0; k++) tick();
    chk("ramping_before_reset", int'(bus.enable_transmit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_flags", dut_flags(), 6'b100000);
    chk("midreset_bias", int'(bus.pa_bias), 0);
    model_reset();
    bus.tx_request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized request / alarm / clear stream
    req_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (req_left == 0) begin
        bus.tx_request = !bus.tx_request;
        req_left = bus.tx_request ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
      end
      req_left--;
      pick = int'($urandom_range(0, 7));
      bus.bias_target = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF :
                        (pick == 2) ? 8'hF5 : 8'($urandom);
      bus.temp_alarm  = ($urandom_range(0, 59) == 0);
      bus.fault_clear = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
